// File: rtl/down_counter_timer.sv
// Loadable down-counting timer: counts a loaded period down to zero under an
// enable, then either parks in DONE (one-shot) or reloads itself (periodic).
module down_counter_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic             en,
  input  logic             auto_reload,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             zero,
  output logic             tc_pulse,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state_dbg
);

  // state_dbg encoding: 0 = IDLE, 1 = RUN, 2 = DONE.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
    end
  end

  // Priority: clr, then load, then counting. tc_d defaults low so the pulse
  // lasts exactly one cycle unless another expiry follows immediately.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    tc_d     = 1'b0;
    if (clr) begin
      state_d = IDLE;
      count_d = '0;
    end else if (load) begin
      reload_d = data_in;
      count_d  = data_in;
      state_d  = (data_in != '0) ? RUN : IDLE;
    end else begin
      case (state_q)
        RUN: begin
          if (en) begin
            if (count_q == WIDTH'(1)) begin
              tc_d = 1'b1;
              if (auto_reload) begin
                count_d = reload_q;
              end else begin
                count_d = '0;
                state_d = DONE;
              end
            end else if (count_q > WIDTH'(1)) begin
              count_d = count_q - WIDTH'(1);
            end
          end
        end
        DONE: begin
          count_d = '0;
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  assign count     = count_q;
  assign zero      = (count_q == '0);
  assign tc_pulse  = tc_q;
  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_down_counter_timer.sv
// Self-checking bench for down_counter_timer: a behavioural model feeds an
// expected queue that is drained one entry per clock, plus directed checks.
module tb_down_counter_timer;

  localparam int W = 10;  // {state, count, zero, tc_pulse, busy, done}

  logic       clk;
  logic       rst;
  logic       load;
  logic [3:0] data_in;
  logic       en;
  logic       auto_reload;
  logic       clr;
  logic [3:0] count;
  logic       zero;
  logic       tc_pulse;
  logic       busy;
  logic       done;
  logic [1:0] state_dbg;

  down_counter_timer #(.WIDTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .data_in    (data_in),
    .en         (en),
    .auto_reload(auto_reload),
    .clr        (clr),
    .count      (count),
    .zero       (zero),
    .tc_pulse   (tc_pulse),
    .busy       (busy),
    .done       (done),
    .state_dbg  (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] observed();
    return {state_dbg, count, zero, tc_pulse, busy, done};
  endfunction

  // ---------------- reference model ----------------
  logic [1:0] m_state;  // 0 IDLE, 1 RUN, 2 DONE
  logic [3:0] m_count;
  logic [3:0] m_reload;
  logic       m_tc;

  task automatic model_reset();
    m_state  = 2'd0;
    m_count  = 4'd0;
    m_reload = 4'd0;
    m_tc     = 1'b0;
  endtask

  task automatic model_step(input logic ld, input logic [3:0] din, input logic e,
                            input logic ar, input logic cl);
    m_tc = 1'b0;
    if (cl) begin
      m_state = 2'd0;
      m_count = 4'd0;
    end else if (ld) begin
      m_reload = din;
      m_count  = din;
      m_state  = (din == 4'd0) ? 2'd0 : 2'd1;
    end else if (m_state == 2'd1 && e) begin
      if (m_count == 4'd1) begin
        m_tc = 1'b1;
        if (ar) m_count = m_reload;
        else begin
          m_count = 4'd0;
          m_state = 2'd2;
        end
      end else begin
        m_count = m_count - 4'd1;
      end
    end
  endtask

  function automatic logic [W-1:0] model_exp();
    return {m_state, m_count, (m_count == 4'd0), m_tc, (m_state == 2'd1), (m_state == 2'd2)};
  endfunction

  // ---------------- driver ----------------
  task automatic drive_cycle(input string tag, input logic ld, input logic [3:0] din,
                             input logic e, input logic ar, input logic cl);
    @(negedge clk);
    load        = ld;
    data_in     = din;
    en          = e;
    auto_reload = ar;
    clr         = cl;
    model_step(ld, din, e, ar, cl);
    exp_q.push_back(model_exp());
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) check({tag, "_sb_empty"}, W'(0), W'(1));
    else check(tag, observed(), exp_q.pop_front());
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; load = 1'b0; data_in = 4'd0; en = 1'b0; auto_reload = 1'b0; clr = 1'b0;
    model_reset();
    #2;
    check("reset_async", observed(), {2'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0});
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold", observed(), {2'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    rst = 1'b0;

    // IDLE ignores en
    for (int i = 0; i < 3; i++) drive_cycle("idle_en", 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);

    // Reset mid-run at count 7, checked before the next clock edge
    drive_cycle("rmr_load", 1'b1, 4'd9, 1'b1, 1'b0, 1'b0);
    drive_cycle("rmr_run", 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    drive_cycle("rmr_run", 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    check("rmr_cnt7", W'(count), W'(4'd7));
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rmr_async", observed(), {2'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0});
    model_reset();
    @(posedge clk);
    #1;
    check("rmr_hold", observed(), {2'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    rst = 1'b0;

    // One-shot load of 13
    drive_cycle("os_load", 1'b1, 4'd13, 1'b1, 1'b0, 1'b0);
    check("os_load_cnt", W'(count), W'(4'd13));
    for (int k = 1; k <= 13; k++) begin
      drive_cycle("os_run", 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
      check("os_cnt", W'(count), W'(13 - k));
      check("os_tc", W'(tc_pulse), W'(k == 13));
    end
    for (int k = 0; k < 20; k++) begin
      drive_cycle("os_done", 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
      check("os_done_flags", W'({done, busy, tc_pulse, count}), W'({1'b1, 1'b0, 1'b0, 4'd0}));
    end

    // Periodic load of 3
    drive_cycle("per_load", 1'b1, 4'd3, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 7; k++) begin
      logic [3:0] seq [7];
      seq = '{4'd2, 4'd1, 4'd3, 4'd2, 4'd1, 4'd3, 4'd2};
      drive_cycle("per_run", 1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
      check("per_cnt", W'(count), W'(seq[k]));
      check("per_tc", W'(tc_pulse), W'(k == 2 || k == 5));
      check("per_zero", W'(zero), W'(0));
    end

    // Periodic N=1: tc held high on every enabled cycle
    drive_cycle("n1_load", 1'b1, 4'd1, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      drive_cycle("n1_run", 1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
      check("n1_tc", W'(tc_pulse), W'(1));
    end

    // Pause: load 5, two enabled, four paused, then finish
    drive_cycle("pause_load", 1'b1, 4'd5, 1'b0, 1'b0, 1'b0);
    repeat (2) drive_cycle("pause_en", 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      drive_cycle("pause_hold", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
      check("pause_cnt", W'({busy, count}), W'({1'b1, 4'd3}));
    end
    repeat (3) drive_cycle("pause_resume", 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    check("pause_tc", W'({tc_pulse, done, count}), W'({1'b1, 1'b1, 4'd0}));

    // Load collides with expiry
    drive_cycle("col_load", 1'b1, 4'd2, 1'b1, 1'b0, 1'b0);
    drive_cycle("col_run", 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    drive_cycle("col_reload", 1'b1, 4'd9, 1'b1, 1'b0, 1'b0);
    check("col_state", W'({busy, tc_pulse, count}), W'({1'b1, 1'b0, 4'd9}));
    drive_cycle("col_clr", 1'b1, 4'd6, 1'b1, 1'b0, 1'b1);
    check("col_clr_idle", W'({busy, done, count}), W'({1'b0, 1'b0, 4'd0}));

    // Zero load
    drive_cycle("zl_load", 1'b1, 4'd0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      drive_cycle("zl_en", 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
      check("zl_flags", W'({zero, tc_pulse, busy}), W'({1'b1, 1'b0, 1'b0}));
    end

    // Maximum load of 15
    drive_cycle("max_load", 1'b1, 4'd15, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 15; k++) begin
      drive_cycle("max_run", 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
      check("max_tc", W'(tc_pulse), W'(k == 15));
    end

    // Random mix, auto_reload toggling freely
    for (int i = 0; i < 400; i++) begin
      drive_cycle("rand",
                  ($urandom_range(0, 9) == 0),
                  4'($urandom_range(0, 15)),
                  ($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 1)),
                  ($urandom_range(0, 29) == 0));
    end

    check("sb_drain", W'(exp_q.size()), W'(0));
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/down_counter_timer.md
Name: down_counter_timer

Overview:
Loadable down-counting timer. It is the count-down counterpart of the team's 4-bit loadable up counter (clk, rst, load, data_in, count). The value presented on data_in is loaded, then decremented to zero under an enable. On expiry it either stops in a done state or auto-reloads for periodic operation. It serves as the timeout and period generator next to the up counter in the same datapath.

Parameters:
WIDTH, 4, width of data_in, count and the internal reload register

Ports:
clk  input  1  system clock; all state changes on its rising edge
rst  input  1  asynchronous, active-high reset
load  input  1  synchronous load strobe; captures data_in into count and the reload register
data_in  input  WIDTH  load value (terminal period in clock cycles)
en  input  1  count enable; decrement only when high
auto_reload  input  1  1 = periodic mode (reload on expiry); 0 = one-shot mode (stop at 0)
clr  input  1  synchronous clear to IDLE
count  output  WIDTH  current count value, registered
zero  output  1  combinational, (count == 0)
tc_pulse  output  1  registered, one-cycle pulse on expiry
busy  output  1  state == RUN
done  output  1  state == DONE

Behaviour:
- Reset (asynchronous, rst=1): state=IDLE, count=0, reload register=0, tc_pulse=0, busy=0, done=0, zero=1. Outputs hold these values for as long as rst is high.
- States: IDLE, RUN, DONE. Encoding is free; busy and done decode from the state.
- Priority at each rising edge: clr > load > count/expiry logic.
- clr=1: state=IDLE, count=0, tc_pulse=0. The reload register is unchanged.
- load=1 in any state:
  - reload register <= data_in, count <= data_in, tc_pulse=0.
  - Next state is RUN if data_in != 0, otherwise IDLE.
  - A load mid-run restarts the timer. No tc_pulse is produced, even if count==1 and en=1 in the same cycle.
- IDLE: count holds and en is ignored.
- RUN, en=0: count holds (pause). State stays RUN. tc_pulse=0.
- RUN, en=1, count > 1: count <= count - 1.
- RUN, en=1, count == 1 (expiry): tc_pulse <= 1 for exactly one cycle.
  - auto_reload=1: count <= reload register, stay in RUN. The count never shows 0 in this mode.
  - auto_reload=0: count <= 0, state <= DONE.
- auto_reload is sampled at the expiry edge only. It may change freely at other times.
- DONE: count=0, done=1. Stays in DONE until load or clr; en is ignored.
- Timing:
  - One-shot load of N with en held high: tc_pulse and done are asserted after the N-th rising edge following the load edge.
  - Periodic mode: tc_pulse repeats every N enabled cycles.
- Arithmetic: unsigned, WIDTH bits. Decrement never wraps because 0 is never decremented. A maximum load of 2^WIDTH-1 is legal.
- tc_pulse is registered and deasserts on the following edge unless a new expiry occurs. A periodic N=1 timer gives tc_pulse held high on every enabled cycle.
- No X propagation: data_in is sampled only when load=1.

Test Plan:
- Reset mid-run: rst pulse during count=7 -> count=0, state IDLE, zero=1, busy=0 immediately (asynchronous, before the next clk edge).
- One-shot: load=1, data_in=4'd13, then en=1, auto_reload=0 -> count 13,12,...,1,0 on successive edges. tc_pulse high exactly one cycle as count reaches 0, then done=1, busy=0, count held at 0 for 20 more cycles.
- Periodic: load 4'd3, en=1, auto_reload=1 -> count 3,2,1,3,2,1,3. tc_pulse high one cycle each time count goes 1->3, i.e. every 3 cycles, zero never asserted.
- Pause: load 4'd5, en=1 for 2 cycles (count 3), en=0 for 4 cycles -> count holds at 3, busy=1. en=1 again -> 2,1,0 with tc_pulse.
- Collisions: load 4'd9 on the same edge as expiry (count=1, en=1) -> count=9, tc_pulse=0, state RUN. clr together with load -> IDLE, count=0.
- Zero load: load 4'd0 -> state IDLE, zero=1, no tc_pulse, en=1 has no effect. Maximum load 4'd15 -> 15 enabled cycles to expiry.
